// File: rtl/mem_pkg.sv
// Shared types and helpers for the load/store unit.
// MEM_ACCESS_SPLIT_EN adds the REQ2/RESP2 states for split misaligned accesses.
package mem_pkg;

  localparam int OP_SIGNED = 0;
  localparam int OP_BYTE   = 1;
  localparam int OP_HALF   = 2;
  localparam int OP_WORD   = 3;
  localparam int OP_STORE  = 4;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD,
    SZ_BAD
  } size_e;

`ifdef MEM_ACCESS_SPLIT_EN
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RESP,
    REQ2,
    RESP2
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_e;
`endif

  // Argument is {word, half, byte}; anything but one-hot is illegal.
  function automatic size_e decode_size(logic [2:0] sz);
    size_e s;
    unique case (sz)
      3'b001:  s = SZ_BYTE;
      3'b010:  s = SZ_HALF;
      3'b100:  s = SZ_WORD;
      default: s = SZ_BAD;
    endcase
    return s;
  endfunction

  function automatic logic misaligned(size_e s, logic [1:0] a);
    return (s == SZ_HALF && a[0]) ||
           (s == SZ_WORD && a != 2'b00);
  endfunction

  function automatic logic [3:0] size_mask(size_e s);
    logic [3:0] m;
    unique case (s)
      SZ_BYTE: m = 4'b0001;
      SZ_HALF: m = 4'b0011;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] replicate(size_e s, logic [31:0] w);
    logic [31:0] r;
    unique case (s)
      SZ_BYTE: r = {4{w[7:0]}};
      SZ_HALF: r = {2{w[15:0]}};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: merge two beats, shift to lane 0,
// then sign- or zero-extend to 32 bits.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] lo_i,
  input  logic [31:0] hi_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  output logic [31:0] data_o
);

  logic [31:0] sh;

  assign sh = 32'({hi_i, lo_i} >> {off_i, 3'b000});

  always_comb begin
    data_o = sh;
    unique case (size_i)
      SZ_BYTE: data_o = {{24{sign_i & sh[7]}}, sh[7:0]};
      SZ_HALF: data_o = {{16{sign_i & sh[15]}}, sh[15:0]};
      default: data_o = sh;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between execute and a req/gnt/rvalid data bus.
// MEM_ACCESS_SPLIT_EN: split misaligned accesses into two word beats.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic [4:0]  mem_op_en_i,
  input  logic [31:0] ex_addr_i,
  input  logic [31:0] ex_wdata_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        flush_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        misalign_exc_o
);

  state_e      state_q;
  size_e       size_d;
  size_e       size_q;
  logic        store_q;
  logic        sign_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic        flushed_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wd_q;
  logic [3:0]  be_q;
  logic        wbv_q;
  logic [31:0] wbd_q;
  logic        exc_q;

  logic        mis_d;
  logic        bad_d;
  logic        kill;
  logic [4:0]  sh_d;
  logic [31:0] rep_d;
  logic [31:0] wd_d;
  logic [3:0]  be_d;
  logic [31:0] al_lo;
  logic [31:0] al_hi;
  logic [31:0] al_data;

  assign size_d = decode_size({mem_op_en_i[OP_WORD],
                               mem_op_en_i[OP_HALF],
                               mem_op_en_i[OP_BYTE]});
  assign mis_d  = misaligned(size_d, ex_addr_i[1:0]);
  assign sh_d   = {ex_addr_i[1:0], 3'b000};
  assign rep_d  = replicate(size_d, ex_wdata_i);
  assign be_d   = size_mask(size_d) << ex_addr_i[1:0];
  assign wd_d   = rep_d << sh_d;
  assign kill   = flush_i | flushed_q;

`ifdef MEM_ACCESS_SPLIT_EN
  logic        split_q;
  logic [3:0]  be_hi_q;
  logic [31:0] wd_hi_q;
  logic [31:0] lo_q;
  logic [3:0]  be_hi_d;
  logic [31:0] wd_hi_d;

  // Lanes that spill past byte 3 go to the next word.
  assign be_hi_d = 4'(({4'b0000, size_mask(size_d)}
                       << ex_addr_i[1:0]) >> 4);
  assign wd_hi_d = 32'(({32'd0, rep_d} << sh_d) >> 32);
  assign bad_d   = (size_d == SZ_BAD);
  assign al_lo   = (state_q == RESP2) ? lo_q : bus_rdata_i;
  assign al_hi   = (state_q == RESP2) ? bus_rdata_i : 32'd0;
`else
  assign bad_d   = (size_d == SZ_BAD) || mis_d;
  assign al_lo   = bus_rdata_i;
  assign al_hi   = 32'd0;
`endif

  mem_load_align u_align (
    .lo_i   (al_lo),
    .hi_i   (al_hi),
    .off_i  (off_q),
    .size_i (size_q),
    .sign_i (sign_q),
    .data_o (al_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      size_q    <= SZ_BYTE;
      store_q   <= 1'b0;
      sign_q    <= 1'b0;
      off_q     <= 2'b00;
      rd_q      <= 5'd0;
      flushed_q <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wd_q      <= 32'd0;
      be_q      <= 4'd0;
      wbv_q     <= 1'b0;
      wbd_q     <= 32'd0;
      exc_q     <= 1'b0;
`ifdef MEM_ACCESS_SPLIT_EN
      split_q   <= 1'b0;
      be_hi_q   <= 4'd0;
      wd_hi_q   <= 32'd0;
      lo_q      <= 32'd0;
`endif
    end else begin
      wbv_q <= 1'b0;
      exc_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (ex_valid_i && bad_d) begin
            exc_q <= 1'b1;
          end else if (ex_valid_i) begin
            state_q   <= REQ;
            req_q     <= 1'b1;
            we_q      <= mem_op_en_i[OP_STORE];
            addr_q    <= {ex_addr_i[31:2], 2'b00};
            be_q      <= be_d;
            wd_q      <= wd_d;
            size_q    <= size_d;
            store_q   <= mem_op_en_i[OP_STORE];
            sign_q    <= mem_op_en_i[OP_SIGNED];
            off_q     <= ex_addr_i[1:0];
            rd_q      <= ex_rd_i;
            flushed_q <= 1'b0;
`ifdef MEM_ACCESS_SPLIT_EN
            split_q   <= mis_d;
            be_hi_q   <= be_hi_d;
            wd_hi_q   <= wd_hi_d;
`endif
          end
        end
        REQ: begin
          if (bus_gnt_i) begin
            req_q     <= 1'b0;
            flushed_q <= flush_i;
            if (!store_q) begin
              state_q <= RESP;
            end
`ifdef MEM_ACCESS_SPLIT_EN
            else if (split_q && !flush_i) begin
              state_q <= REQ2;
              req_q   <= 1'b1;
              addr_q  <= addr_q + 32'd4;
              be_q    <= be_hi_q;
              wd_q    <= wd_hi_q;
            end
`endif
            else begin
              state_q <= IDLE;
            end
          end else if (flush_i) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        RESP: begin
          if (flush_i) flushed_q <= 1'b1;
          if (bus_rvalid_i) begin
`ifdef MEM_ACCESS_SPLIT_EN
            if (split_q && !kill) begin
              state_q <= REQ2;
              req_q   <= 1'b1;
              addr_q  <= addr_q + 32'd4;
              be_q    <= be_hi_q;
              wd_q    <= wd_hi_q;
              lo_q    <= bus_rdata_i;
            end else
`endif
            begin
              state_q <= IDLE;
              wbv_q   <= !kill;
              wbd_q   <= al_data;
            end
          end
        end
`ifdef MEM_ACCESS_SPLIT_EN
        REQ2: begin
          if (bus_gnt_i) begin
            req_q     <= 1'b0;
            flushed_q <= flush_i;
            state_q   <= store_q ? IDLE : RESP2;
          end else if (flush_i) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        RESP2: begin
          if (flush_i) flushed_q <= 1'b1;
          if (bus_rvalid_i) begin
            state_q <= IDLE;
            wbv_q   <= !kill;
            wbd_q   <= al_data;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ex_ready_o     = (state_q == IDLE);
  assign bus_req_o      = req_q;
  assign bus_we_o       = we_q;
  assign bus_addr_o     = addr_q;
  assign bus_wdata_o    = wd_q;
  assign bus_be_o       = be_q;
  assign wb_valid_o     = wbv_q;
  assign wb_rd_o        = rd_q;
  assign wb_data_o      = wbd_q;
  assign misalign_exc_o = exc_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table, corner sequences,
// and random accesses against a byte-level reference model.
module tb_mem_access_unit;

`ifdef MEM_ACCESS_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [4:0]  op = 5'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [4:0]  rd = 5'd0;
  logic        flush = 1'b0;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ex_valid_i     (ex_valid),
    .ex_ready_o     (ex_ready),
    .mem_op_en_i    (op),
    .ex_addr_i      (addr),
    .ex_wdata_i     (wdata),
    .ex_rd_i        (rd),
    .flush_i        (flush),
    .bus_req_o      (bus_req),
    .bus_we_o       (bus_we),
    .bus_addr_o     (bus_addr),
    .bus_wdata_o    (bus_wdata),
    .bus_be_o       (bus_be),
    .bus_gnt_i      (gnt),
    .bus_rvalid_i   (rvalid),
    .bus_rdata_i    (rdata),
    .wb_valid_o     (wb_valid),
    .wb_rd_o        (wb_rd),
    .wb_data_o      (wb_data),
    .misalign_exc_o (exc)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stall;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] wb;
  } vec_t;

  vec_t tbl [8];

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] lane_mask(logic [3:0] be);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{be[k]}};
    return m;
  endfunction

  // Byte-level model: which lanes a store touches, what a load returns.
  task automatic model(input logic [4:0] o, input logic [31:0] a,
                       input logic [31:0] w, lo, hi,
                       output int nb, output logic [3:0] be0, be1,
                       output logic [31:0] wd0, wd1, wbx);
    int n;
    int off;
    int lane;
    logic [7:0] mem [8];
    logic [63:0] v;
    n   = o[1] ? 1 : (o[2] ? 2 : 4);
    off = int'(a[1:0]);
    nb  = (SPLIT && ((n == 2 && off % 2 == 1) ||
                     (n == 4 && off != 0))) ? 2 : 1;
    be0 = 4'd0; be1 = 4'd0; wd0 = 32'd0; wd1 = 32'd0;
    for (int i = 0; i < n; i++) begin
      lane = off + i;
      if (lane < 4) begin
        be0[lane] = 1'b1;
        wd0[8*lane +: 8] = w[8*i +: 8];
      end else begin
        be1[lane-4] = 1'b1;
        wd1[8*(lane-4) +: 8] = w[8*i +: 8];
      end
    end
    for (int k = 0; k < 4; k++) begin
      mem[k]   = lo[8*k +: 8];
      mem[k+4] = hi[8*k +: 8];
    end
    v = 64'd0;
    for (int i = 0; i < n; i++) v = v | (64'(mem[off+i]) << (8*i));
    if (o[0] && n < 4 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
    wbx = v[31:0];
  endtask

  task automatic accept(input logic [4:0] o, input logic [31:0] a, w,
                        input logic [4:0] r);
    op = o; addr = a; wdata = w; rd = r; ex_valid = 1'b1;
    chk("ex_ready_accept", ex_ready, 1);
    @(negedge clk);
    ex_valid = 1'b0; op = 5'($urandom); addr = $urandom;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!bus_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("bus_req_seen", bus_req, 1);
  endtask

  task automatic xfer(input logic [4:0] o, input logic [31:0] a, w,
                      input logic [4:0] r, input logic [31:0] lo, hi,
                      input int stall, rvd, nb,
                      input logic [3:0] be0, be1,
                      input logic [31:0] wd0, wd1, wbx);
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic [31:0] beat;
    accept(o, a, w, r);
    for (int b = 0; b < nb; b++) begin
      ebe  = (b == 0) ? be0 : be1;
      ewd  = (b == 0) ? wd0 : wd1;
      beat = (b == 0) ? lo : hi;
      wait_req();
      for (int s = 0; s <= stall; s++) begin
        chk("bus_req_hold", bus_req, 1);
        chk("bus_addr", bus_addr, {a[31:2], 2'b00} + 32'(4*b));
        chk("bus_be", bus_be, ebe);
        chk("bus_we", bus_we, o[4]);
        if (o[4]) chk("bus_wdata", bus_wdata & lane_mask(ebe), ewd);
        gnt = (s == stall);
        @(negedge clk);
      end
      gnt = 1'b0;
      if (!o[4]) begin
        chk("req_drop", bus_req, 0);
        repeat (rvd) @(negedge clk);
        rvalid = 1'b1; rdata = beat;
        @(negedge clk);
        rvalid = 1'b0; rdata = $urandom;
      end
    end
    if (!o[4]) begin
      chk("wb_valid", wb_valid, 1);
      chk("wb_data", wb_data, wbx);
      chk("wb_rd", wb_rd, r);
    end else begin
      chk("store_done", bus_req, 0);
    end
    @(negedge clk);
    chk("wb_pulse", wb_valid, 0);
    chk("idle_ready", ex_ready, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nb;
    logic [3:0]  be0, be1;
    logic [31:0] wd0, wd1, wbx, a, w, lo, hi;
    logic [4:0]  o;
    int sz;

    tbl[0] = '{5'b00011, 32'h1003, 32'h0, 32'h80123456, 0,
               4'b1000, 32'h0, 32'hFFFFFF80};
    tbl[1] = '{5'b00010, 32'h1003, 32'h0, 32'h80123456, 0,
               4'b1000, 32'h0, 32'h00000080};
    tbl[2] = '{5'b10100, 32'h2002, 32'h1234, 32'h0, 3,
               4'b1100, 32'h12340000, 32'h0};
    tbl[3] = '{5'b01000, 32'h4000, 32'h0, 32'hCAFEBABE, 1,
               4'b1111, 32'h0, 32'hCAFEBABE};
    tbl[4] = '{5'b00101, 32'h4002, 32'h0, 32'h8001ABCD, 0,
               4'b1100, 32'h0, 32'hFFFF8001};
    tbl[5] = '{5'b00100, 32'h4000, 32'h0, 32'h1234ABCD, 2,
               4'b0011, 32'h0, 32'h0000ABCD};
    tbl[6] = '{5'b10010, 32'h5001, 32'h000000A5, 32'h0, 1,
               4'b0010, 32'h0000A500, 32'h0};
    tbl[7] = '{5'b11000, 32'h6000, 32'hDEADBEEF, 32'h0, 0,
               4'b1111, 32'hDEADBEEF, 32'h0};

    repeat (2) @(negedge clk);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_be", bus_be, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_exc", exc, 0);
    chk("rst_ready", ex_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("idle_flush_req", bus_req, 0);
    chk("idle_flush_ready", ex_ready, 1);

    for (int i = 0; i < 8; i++) begin
      xfer(tbl[i].op, tbl[i].addr, tbl[i].wdata, 5'(i + 1),
           tbl[i].rdata, 32'h0, tbl[i].stall, 1, 1,
           tbl[i].be, 4'h0, tbl[i].wd, 32'h0, tbl[i].wb);
    end

`ifdef MEM_ACCESS_SPLIT_EN
    xfer(5'b01000, 32'h3001, 32'h0, 5'd3, 32'hDDCCBBAA, 32'h44332211,
         0, 1, 2, 4'b1110, 4'b0001, 32'h0, 32'h0, 32'h11DDCCBB);
`else
    accept(5'b01000, 32'h3001, 32'h0, 5'd3);
    chk("mis_exc", exc, 1);
    chk("mis_no_req", bus_req, 0);
    @(negedge clk);
    chk("mis_exc_pulse", exc, 0);
    chk("mis_no_req2", bus_req, 0);
    chk("mis_ready", ex_ready, 1);
`endif

    accept(5'b01100, 32'h0, 32'h0, 5'd4);
    chk("bad_size_exc", exc, 1);
    chk("bad_size_no_req", bus_req, 0);
    @(negedge clk);
    chk("bad_size_pulse", exc, 0);
    chk("bad_size_ready", ex_ready, 1);

    accept(5'b01000, 32'h7000, 32'h0, 5'd5);
    chk("fr_req", bus_req, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fr_req_drop", bus_req, 0);
    chk("fr_ready", ex_ready, 1);

    accept(5'b01000, 32'h7000, 32'h0, 5'd6);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0; flush = 1'b1;
    chk("fg_busy", ex_ready, 0);
    @(negedge clk);
    flush = 1'b0; rvalid = 1'b1; rdata = 32'h12345678;
    @(negedge clk);
    rvalid = 1'b0;
    chk("fg_no_wb", wb_valid, 0);
    chk("fg_ready", ex_ready, 1);

    accept(5'b01000, 32'h7004, 32'h0, 5'd7);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rr_req", bus_req, 0);
    chk("rr_ready", ex_ready, 1);
    rvalid = 1'b1; rdata = 32'hA5A5A5A5;
    @(negedge clk);
    rvalid = 1'b0;
    chk("rr_late_rvalid", wb_valid, 0);
    chk("rr_ready2", ex_ready, 1);

    for (int i = 0; i < 40; i++) begin
      sz = int'($urandom_range(0, 2));
      o  = {1'($urandom), sz == 2, sz == 1, sz == 0, 1'($urandom)};
      a  = $urandom;
`ifndef MEM_ACCESS_SPLIT_EN
      a  = a & ~((32'd1 << sz) - 32'd1);
`endif
      w  = $urandom;
      lo = $urandom;
      hi = $urandom;
      model(o, a, w, lo, hi, nb, be0, be1, wd0, wd1, wbx);
      xfer(o, a, w, 5'($urandom), lo, hi,
           int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
           nb, be0, be1, wd0, wd1, wbx);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
